// File: rtl/swervolf_ram_loader.sv
// Boot loader: packs a length-prefixed byte stream into 64-bit AXI4 single-beat RAM writes,
// then releases the core from reset. Define SWERVOLF_LOADER_CHECKSUM_EN to require a trailing sum byte.
`timescale 1ns/1ps
module swervolf_ram_loader #(
    parameter int          ID_WIDTH  = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] MEM_SIZE  = 32'h10000,
    parameter int          AXI_ID    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_skip,
    input  logic [7:0]          i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [ID_WIDTH-1:0] o_awid,
    output logic [31:0]         o_awaddr,
    output logic [7:0]          o_awlen,
    output logic [2:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [63:0]         o_wdata,
    output logic [7:0]          o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [ID_WIDTH-1:0] i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready,
    output logic                o_core_rstn,
    output logic                o_done,
    output logic                o_err
);

`ifdef SWERVOLF_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HDR, COLLECT, WRITE, RESP, DONE, ERR, CSUM} state_t;
    localparam state_t TAIL = CSUM;
`else
    typedef enum logic [2:0] {HDR, COLLECT, WRITE, RESP, DONE, ERR} state_t;
    localparam state_t TAIL = DONE;
`endif

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [31:0] remaining_q, remaining_d;
    logic [2:0]  k_q, k_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    logic        accept;
    logic [31:0] hdr_len;
    logic        unused_bid;

    assign accept     = ready_q & i_valid;
    // The header is shifted into remaining, LSB first; on the 4th byte this is LEN.
    assign hdr_len    = {i_data, remaining_q[31:8]};
    assign unused_bid = ^i_bid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HDR;
            ready_q     <= 1'b0;
            hdr_cnt_q   <= 2'd0;
            remaining_q <= 32'd0;
            k_q         <= 3'd0;
            awaddr_q    <= BASE_ADDR;
            wdata_q     <= 64'd0;
            wstrb_q     <= 8'd0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            hdr_cnt_q   <= hdr_cnt_d;
            remaining_q <= remaining_d;
            k_q         <= k_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        remaining_d = remaining_q;
        k_d         = k_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            HDR: begin
                // ready is still low only in the first cycle after reset: the one chance to skip.
                if (!ready_q) begin
                    if (i_skip) state_d = DONE;
                end else if (accept) begin
                    hdr_cnt_d   = hdr_cnt_q + 2'd1;
                    remaining_d = hdr_len;
                    if (hdr_cnt_q == 2'd3) begin
                        if (hdr_len == 32'd0)         state_d = TAIL;
                        else if (hdr_len > MEM_SIZE)  state_d = ERR;
                        else                          state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    wdata_d[{k_q, 3'b000} +: 8] = i_data;
                    wstrb_d[k_q]                = 1'b1;
                    remaining_d                 = remaining_q - 32'd1;
                    k_d                         = k_q + 3'd1;
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
                    sum_d                       = sum_q + i_data;
`endif
                    if (k_q == 3'd7 || remaining_q == 32'd1) begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                awvalid_d = awvalid_q & ~i_awready;
                wvalid_d  = wvalid_q & ~i_wready;
                if (!awvalid_d && !wvalid_d) state_d = RESP;
            end
            RESP: begin
                if (i_bvalid) begin
                    if (i_bresp != 2'b00) begin
                        state_d = ERR;
                    end else begin
                        awaddr_d = awaddr_q + 32'd8;
                        wdata_d  = 64'd0;
                        wstrb_d  = 8'd0;
                        k_d      = 3'd0;
                        state_d  = (remaining_q == 32'd0) ? TAIL : COLLECT;
                    end
                end
            end
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) state_d = (i_data == sum_q) ? DONE : ERR;
            end
`endif
            default: ;
        endcase

        // Registered ready follows the state being entered, so it drops the cycle after the last byte.
        ready_d = (state_d == HDR) || (state_d == COLLECT);
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
        if (state_d == CSUM) ready_d = 1'b1;
`endif
    end

    assign o_ready     = ready_q;
    assign o_awid      = ID_WIDTH'(AXI_ID);
    assign o_awaddr    = awaddr_q;
    assign o_awlen     = 8'd0;
    assign o_awsize    = 3'd3;
    assign o_awburst   = 2'b01;
    assign o_awvalid   = awvalid_q;
    assign o_wdata     = wdata_q;
    assign o_wstrb     = wstrb_q;
    assign o_wlast     = 1'b1;
    assign o_wvalid    = wvalid_q;
    assign o_bready    = (state_q == RESP);
    assign o_done      = (state_q == DONE);
    assign o_err       = (state_q == ERR);
    assign o_core_rstn = (state_q == DONE);

endmodule

// File: tb/tb_swervolf_ram_loader.sv
// Randomized bench for swervolf_ram_loader: a byte-level load model predicts beats, byte count and outcome.
`timescale 1ns/1ps
module tb_swervolf_ram_loader;

    localparam int          ID_WIDTH = 6;
    localparam logic [31:0] BASE     = 32'h8000_0100;
    localparam logic [31:0] MEMSZ    = 32'd64;
    localparam int          AXI_ID   = 5;

    logic                clk;
    logic                rst_n;
    logic                i_skip;
    logic [7:0]          i_data;
    logic                i_valid;
    logic                o_ready;
    logic [ID_WIDTH-1:0] o_awid;
    logic [31:0]         o_awaddr;
    logic [7:0]          o_awlen;
    logic [2:0]          o_awsize;
    logic [1:0]          o_awburst;
    logic                o_awvalid;
    logic                i_awready;
    logic [63:0]         o_wdata;
    logic [7:0]          o_wstrb;
    logic                o_wlast;
    logic                o_wvalid;
    logic                i_wready;
    logic [ID_WIDTH-1:0] i_bid;
    logic [1:0]          i_bresp;
    logic                i_bvalid;
    logic                o_bready;
    logic                o_core_rstn;
    logic                o_done;
    logic                o_err;

    swervolf_ram_loader #(
        .ID_WIDTH (ID_WIDTH),
        .BASE_ADDR(BASE),
        .MEM_SIZE (MEMSZ),
        .AXI_ID   (AXI_ID)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_skip     (i_skip),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_awid     (o_awid),
        .o_awaddr   (o_awaddr),
        .o_awlen    (o_awlen),
        .o_awsize   (o_awsize),
        .o_awburst  (o_awburst),
        .o_awvalid  (o_awvalid),
        .i_awready  (i_awready),
        .o_wdata    (o_wdata),
        .o_wstrb    (o_wstrb),
        .o_wlast    (o_wlast),
        .o_wvalid   (o_wvalid),
        .i_wready   (i_wready),
        .i_bid      (i_bid),
        .i_bresp    (i_bresp),
        .i_bvalid   (i_bvalid),
        .o_bready   (o_bready),
        .o_core_rstn(o_core_rstn),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    logic [7:0]  stream[$];
    logic [31:0] got_addr[$];
    logic [63:0] got_data[$];
    logic [7:0]  got_strb[$];
    int          idx, aw_cnt, w_cnt, b_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input bit skip);
        @(negedge clk);
        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_data    = 8'd0;
        i_awready = 1'b0;
        i_wready  = 1'b0;
        i_bvalid  = 1'b0;
        i_bresp   = 2'b00;
        i_skip    = 1'b0;
        #1;
        check("rst_ready",   64'(o_ready), 64'd0);
        check("rst_awvalid", 64'(o_awvalid), 64'd0);
        check("rst_wvalid",  64'(o_wvalid), 64'd0);
        check("rst_bready",  64'(o_bready), 64'd0);
        check("rst_done",    64'(o_done), 64'd0);
        check("rst_err",     64'(o_err), 64'd0);
        check("rst_corerst", 64'(o_core_rstn), 64'd0);
        check("rst_awaddr",  64'(o_awaddr), 64'(BASE));
        check("rst_wdata",   o_wdata, 64'd0);
        check("rst_wstrb",   64'(o_wstrb), 64'd0);
        check("const_aw",    64'({o_awid, o_awlen, o_awsize, o_awburst, o_wlast}),
                             64'({6'(AXI_ID), 8'd0, 3'd3, 2'b01, 1'b1}));
        repeat (2) @(negedge clk);
        i_skip = skip;
        rst_n  = 1'b1;
    endtask

    // mode: 0 random handshakes, 1 incrementing payload with ready tied high,
    //       2 wready held off 5 cycles after AW, 3 reset while AW is pending
    task automatic run_load(input int len, input bit skip, input int err_beat, input int mode);
        logic [7:0]  pay[$];
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [63:0] ed, p_data;
        logic [7:0]  es, p_strb;
        logic [31:0] p_addr;
        bit          p_aw, p_w, exp_done;
        int          pl, nb, nb_exp, exp_cons, done_cyc, early, stab_err, aw_hs_cyc;
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
        bit          csum_good;
        csum_good = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
`endif

        stream.delete();
        pay.delete();
        sum = 8'd0;
        for (int i = 0; i < 4; i++) stream.push_back(8'(len >> (8 * i)));
        pl = (len > int'(MEMSZ)) ? 8 : len;
        for (int i = 0; i < pl; i++) begin
            b = (mode == 1) ? 8'(i) : 8'($urandom);
            pay.push_back(b);
            stream.push_back(b);
            sum = sum + b;
        end
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
        stream.push_back(csum_good ? sum : (sum ^ 8'h5A));
`endif
        for (int i = 0; i < 4; i++) stream.push_back(8'($urandom));

        nb = (len + 7) / 8;
        if (skip) begin
            nb_exp = 0; exp_cons = 0; exp_done = 1'b1;
        end else if (len > int'(MEMSZ)) begin
            nb_exp = 0; exp_cons = 4; exp_done = 1'b0;
        end else if (err_beat >= 0 && err_beat < nb) begin
            nb_exp   = err_beat + 1;
            exp_cons = 4 + ((len < 8 * (err_beat + 1)) ? len : 8 * (err_beat + 1));
            exp_done = 1'b0;
        end else begin
            nb_exp = nb; exp_cons = 4 + len; exp_done = 1'b1;
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
            exp_cons = exp_cons + 1;
            exp_done = csum_good;
`endif
        end

        do_reset(skip);
        got_addr.delete(); got_data.delete(); got_strb.delete();
        idx = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        done_cyc = -1; early = 0; stab_err = 0; aw_hs_cyc = 0;
        p_aw = 1'b0; p_w = 1'b0; p_addr = 32'd0; p_data = 64'd0; p_strb = 8'd0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            i_valid = (idx < stream.size()) && ((mode == 1) || ($urandom_range(0, 3) != 0));
            i_data  = i_valid ? stream[idx] : 8'($urandom);
            case (mode)
                1: begin i_awready = 1'b1; i_wready = 1'b1; end
                2: begin
                    i_awready = 1'($urandom);
                    i_wready  = (aw_cnt > w_cnt) && (cyc >= aw_hs_cyc + 5);
                end
                3: begin i_awready = 1'b0; i_wready = 1'($urandom); end
                default: begin i_awready = 1'($urandom); i_wready = 1'($urandom); end
            endcase
            i_bvalid = (aw_cnt > b_cnt) && (w_cnt > b_cnt) && ($urandom_range(0, 1) == 1);
            i_bresp  = (i_bvalid && b_cnt == err_beat) ?
                       ((mode == 2) ? 2'b10 : 2'($urandom_range(1, 3))) : 2'b00;
            i_bid    = 6'($urandom);
            i_skip   = 1'($urandom);
            #1;
            if (p_aw && (!o_awvalid || o_awaddr !== p_addr)) stab_err++;
            if (p_w && (!o_wvalid || o_wdata !== p_data || o_wstrb !== p_strb)) stab_err++;
            p_aw = o_awvalid && !i_awready; p_addr = o_awaddr;
            p_w  = o_wvalid && !i_wready;   p_data = o_wdata; p_strb = o_wstrb;
            if (i_valid && o_ready) idx++;
            if (o_awvalid && i_awready) begin
                got_addr.push_back(o_awaddr); aw_cnt++; aw_hs_cyc = cyc;
            end
            if (o_wvalid && i_wready) begin
                got_data.push_back(o_wdata); got_strb.push_back(o_wstrb); w_cnt++;
            end
            if (i_bvalid && o_bready) b_cnt++;
            if (o_core_rstn && !o_done) early++;
            if (mode == 3 && o_awvalid) begin
                #2 rst_n = 1'b0;
                #1;
                check("mid_awvalid", 64'(o_awvalid), 64'd0);
                check("mid_wvalid",  64'(o_wvalid), 64'd0);
                check("mid_ready",   64'(o_ready), 64'd0);
                check("mid_corerst", 64'(o_core_rstn), 64'd0);
                check("mid_awaddr",  64'(o_awaddr), 64'(BASE));
                check("mid_wstrb",   64'(o_wstrb), 64'd0);
                @(negedge clk);
                i_skip = 1'b0; i_valid = 1'b0; i_bvalid = 1'b0;
                rst_n  = 1'b1;
                repeat (2) @(negedge clk);
                #1;
                check("post_rst_ready",  64'(o_ready), 64'd1);
                check("post_rst_awaddr", 64'(o_awaddr), 64'(BASE));
                check("post_rst_done",   64'({o_done, o_err}), 64'd0);
                return;
            end
            if ((o_done || o_err) && done_cyc < 0) done_cyc = cyc;
            if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
        end

        check("finished", 64'(done_cyc >= 0), 64'd1);
        if (skip) check("skip_latency", 64'(done_cyc <= 1), 64'd1);
        check("consumed", 64'(idx), 64'(exp_cons));
        check("aw_count", 64'(aw_cnt), 64'(nb_exp));
        check("w_count",  64'(w_cnt), 64'(nb_exp));
        for (int i = 0; i < nb_exp && i < got_addr.size() && i < got_data.size(); i++) begin
            ed = 64'd0; es = 8'd0;
            for (int j = 0; j < 8; j++)
                if (8 * i + j < len) begin
                    ed[8 * j +: 8] = pay[8 * i + j];
                    es[j]          = 1'b1;
                end
            check("beat_addr", 64'(got_addr[i]), 64'(BASE + 32'(8 * i)));
            check("beat_data", got_data[i], ed);
            check("beat_strb", 64'(got_strb[i]), 64'(es));
        end
        if (mode == 1 && got_data.size() >= 2) begin
            check("beat0_lit", got_data[0], 64'h0706050403020100);
            check("beat1_lit", got_data[1], 64'h0F0E0D0C0B0A0908);
        end
        check("done",        64'(o_done), 64'(exp_done));
        check("err",         64'(o_err), 64'(!exp_done));
        check("core_rstn",   64'(o_core_rstn), 64'(exp_done));
        check("early_rstn",  64'(early), 64'd0);
        check("aw_w_stable", 64'(stab_err), 64'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        i_skip    = 1'b0;
        i_data    = 8'd0;
        i_valid   = 1'b0;
        i_awready = 1'b0;
        i_wready  = 1'b0;
        i_bid     = '0;
        i_bresp   = 2'b00;
        i_bvalid  = 1'b0;

        run_load(16, 1'b1, -1, 0);
        run_load(16, 1'b0, -1, 1);
        run_load(11, 1'b0, -1, 0);
        run_load(int'(MEMSZ) + 1, 1'b0, -1, 0);
        run_load(16, 1'b0, 0, 2);
        run_load(16, 1'b0, -1, 3);
        run_load(0, 1'b0, -1, 0);
        run_load(int'(MEMSZ), 1'b0, -1, 0);
        run_load(24, 1'b0, 1, 0);
        for (int n = 0; n < 12; n++)
            run_load($urandom_range(0, 70), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
